// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the requester-side handshake (req/we/addr/wdata -> gnt/rvalid/rdata/
// busy) and the single-port memory bus (mem_addr/mem_we/mem_din <- mem_dout)
// used by mem_port_arbiter.
//   slave  : arbiter view (consumes requests and mem_dout, drives the rest)
//   master : environment view (requesters plus memory)
// AW/DW must match the parameters of the arbiter instance bound to it.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt;
  logic [2:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [DW-1:0]   mem_din;
  logic [DW-1:0]   mem_dout;

  modport slave (
    input  req, we, addr, wdata, mem_dout,
    output gnt, rvalid, rdata, busy, mem_addr, mem_we, mem_din
  );

  modport master (
    output req, we, addr, wdata, mem_dout,
    input  gnt, rvalid, rdata, busy, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port block memory between instruction fetch (port 0),
// load/store (port 1) and debug/monitor (port 2). One access is in flight at a
// time; the read latency of the memory is hidden behind a req/gnt/rvalid
// handshake.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_port_arbiter_if.slave
//            req/we/addr/wdata in   (port i at [i*AW +: AW] / [i*DW +: DW])
//            gnt/rvalid out         (one-hot, one-cycle pulses)
//            rdata out              (valid while any rvalid bit is high)
//            busy out               (high outside IDLE)
//            mem_addr/mem_we/mem_din out, mem_dout in
//
// Parameters: AW (word address width), DW (data width),
//             RD_LAT (memory read latency in cycles, 1..7).
//
// Build option: MEM_ARB_RR_EN selects round-robin arbitration with a 2-bit
// priority pointer (reset value 1). Without it priority is fixed 1 > 0 > 2.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW     = 6,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  if ((RD_LAT < 1) || (RD_LAT > 7)) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be within 1..7");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t       state_r;
  logic [1:0]   win_r;
  logic         we_r;
  logic [2:0]   cnt_r;
  logic [2:0]   sel_s;
  logic [1:0]   win_s;
  logic         win_vld_s;

  // Returns {found, index} of the first requesting port in the order p0,p1,p2.
  function automatic logic [2:0] pick_in_order(input logic [2:0] r,
                                               input logic [1:0] p0,
                                               input logic [1:0] p1,
                                               input logic [1:0] p2);
    logic [2:0] res;
    if (r[p0]) begin
      res = {1'b1, p0};
    end else if (r[p1]) begin
      res = {1'b1, p1};
    end else if (r[p2]) begin
      res = {1'b1, p2};
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  function automatic logic [2:0] port_onehot(input logic [1:0] p);
    logic [2:0] oh;
    case (p)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

`ifdef MEM_ARB_RR_EN
  logic [1:0] ptr_r;

  // Round-robin winner search starting at the pointer.
  always_comb begin
    sel_s = 3'b000;
    case (ptr_r)
      2'd0:    sel_s = pick_in_order(bus.req, 2'd0, 2'd1, 2'd2);
      2'd2:    sel_s = pick_in_order(bus.req, 2'd2, 2'd0, 2'd1);
      default: sel_s = pick_in_order(bus.req, 2'd1, 2'd2, 2'd0);
    endcase
  end

  // Priority pointer moves past the port just issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= 2'd1;
    end else if (state_r == ST_ISSUE) begin
      case (win_r)
        2'd0:    ptr_r <= 2'd1;
        2'd1:    ptr_r <= 2'd2;
        default: ptr_r <= 2'd0;
      endcase
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // Fixed-priority winner search: load/store first, then fetch, then debug.
  always_comb begin
    sel_s = pick_in_order(bus.req, 2'd1, 2'd0, 2'd2);
  end
`endif

  // Split the search result into valid flag and index.
  always_comb begin
    win_vld_s = sel_s[2];
    win_s     = sel_s[1:0];
  end

  // Transaction FSM; every bus output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      win_r        <= 2'd0;
      we_r         <= 1'b0;
      cnt_r        <= 3'd0;
      bus.gnt      <= 3'b000;
      bus.rvalid   <= 3'b000;
      bus.rdata    <= '0;
      bus.busy     <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_we   <= 1'b0;
      bus.mem_din  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bus.rvalid <= 3'b000;
          if (win_vld_s) begin
            // Operands are latched here so later requester changes are ignored.
            win_r        <= win_s;
            we_r         <= bus.we[win_s];
            bus.mem_addr <= bus.addr[win_s*AW +: AW];
            bus.mem_din  <= bus.wdata[win_s*DW +: DW];
            bus.mem_we   <= bus.we[win_s];
            bus.gnt      <= port_onehot(win_s);
            bus.busy     <= 1'b1;
            state_r      <= ST_ISSUE;
          end else begin
            bus.gnt    <= 3'b000;
            bus.mem_we <= 1'b0;
            bus.busy   <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          bus.gnt    <= 3'b000;
          bus.mem_we <= 1'b0;
          if (we_r) begin
            bus.busy <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            // ISSUE already accounts for one cycle of the read latency.
            cnt_r    <= 3'(RD_LAT - 1);
            bus.busy <= 1'b1;
            state_r  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_r != 3'd0) begin
            cnt_r   <= cnt_r - 3'd1;
            state_r <= ST_WAIT;
          end else begin
            bus.rdata  <= bus.mem_dout;
            bus.rvalid <= port_onehot(win_r);
            state_r    <= ST_RESP;
          end
        end
        ST_RESP: begin
          bus.rvalid <= 3'b000;
          bus.busy   <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          bus.gnt    <= 3'b000;
          bus.rvalid <= 3'b000;
          bus.mem_we <= 1'b0;
          bus.busy   <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Two arbiter instances (RD_LAT=1 and RD_LAT=4) share one requester stimulus;
// sel4 picks which instance is active. Each has its own synchronous memory with
// the matching read pipeline. A transaction-level model (pending set, priority
// rule, timing arithmetic and a shadow memory) predicts every cycle's outputs.
// -----------------------------------------------------------------------------
`define CHK(tag, obs, exp) \
  begin \
    tests++; \
    assert ((obs) === (exp)) else begin \
      fails++; \
      $error("FAIL %s.%s observed=%0h expected=%0h", cur_test, tag, (obs), (exp)); \
    end \
  end

module tb_mem_port_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  string cur_test = "none";

  logic            sel4;
  logic            mem_load;
  logic [2:0]      req_d, we_d;
  logic [3*AW-1:0] addr_d;
  logic [3*DW-1:0] wdata_d;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus4 ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  assign bus1.req   = sel4 ? 3'b000 : req_d;
  assign bus4.req   = sel4 ? req_d : 3'b000;
  assign bus1.we    = we_d;
  assign bus4.we    = we_d;
  assign bus1.addr  = addr_d;
  assign bus4.addr  = addr_d;
  assign bus1.wdata = wdata_d;
  assign bus4.wdata = wdata_d;

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC3C3_0000 ^ (32'h1000_0000 + i * 32'h0001_0203);
  endfunction

  // Memories with RD_LAT-deep read pipelines
  logic [DW-1:0] mem1 [64];
  logic [DW-1:0] mem4 [64];
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe4 [4];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem1[i] <= init_word(i);
    end else if (bus1.mem_we) begin
      mem1[bus1.mem_addr] <= bus1.mem_din;
    end
    pipe1 <= mem1[bus1.mem_addr];
  end

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem4[i] <= init_word(i);
    end else if (bus4.mem_we) begin
      mem4[bus4.mem_addr] <= bus4.mem_din;
    end
    pipe4[0] <= mem4[bus4.mem_addr];
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end

  assign bus1.mem_dout = pipe1;
  assign bus4.mem_dout = pipe4[3];

  // Observed outputs of the active instance
  logic [2:0]    gnt_o, rvalid_o;
  logic [DW-1:0] rdata_o, mem_din_o;
  logic [AW-1:0] mem_addr_o;
  logic          busy_o, mem_we_o;
  assign gnt_o      = sel4 ? bus4.gnt      : bus1.gnt;
  assign rvalid_o   = sel4 ? bus4.rvalid   : bus1.rvalid;
  assign rdata_o    = sel4 ? bus4.rdata    : bus1.rdata;
  assign busy_o     = sel4 ? bus4.busy     : bus1.busy;
  assign mem_we_o   = sel4 ? bus4.mem_we   : bus1.mem_we;
  assign mem_addr_o = sel4 ? bus4.mem_addr : bus1.mem_addr;
  assign mem_din_o  = sel4 ? bus4.mem_din  : bus1.mem_din;

  // Reference model state
  logic [DW-1:0] shadow [2][64];
  int            ptr_m [2];

  function automatic int pick(input logic [2:0] pend, input int ptr);
    int p;
    int res;
    int order [3];
    res = -1;
    order = '{1, 0, 2};
    for (int k = 0; k < 3; k++) begin
`ifdef MEM_ARB_RR_EN
      p = (ptr + k) % 3;
`else
      p = order[k];
`endif
      if (res < 0 && pend[p]) res = p;
    end
    return res;
  endfunction

  // Issue a set of simultaneous requests and check every cycle until all done.
  task automatic run_batch(input string name, input logic [2:0] ports, input logic [2:0] wes,
                           input logic [3*AW-1:0] addrs, input logic [3*DW-1:0] wdatas);
    int            lat, ix, cycle, next_gnt, rv_cycle, rv_port, busy_from, busy_to, w;
    logic [2:0]    pend, exp_gnt, exp_rv;
    logic [DW-1:0] rv_data;
    logic [AW-1:0] cur_addr, a;
    cur_test = name;
    lat = sel4 ? 4 : 1;
    ix  = sel4 ? 1 : 0;
    pend = ports; cycle = 0; next_gnt = 1; rv_cycle = -1; rv_port = 0;
    busy_from = -1; busy_to = -1; rv_data = '0; cur_addr = '0;
    we_d = wes; addr_d = addrs; wdata_d = wdatas; req_d = ports;
    while (1) begin
      @(posedge clk); #1;
      cycle++;
      w = -1;
      exp_gnt = 3'b000;
      if (pend != 3'b000 && cycle == next_gnt) begin
        w = pick(pend, ptr_m[ix]);
        exp_gnt = 3'b001 << w;
      end
      exp_rv = (cycle == rv_cycle) ? (3'b001 << rv_port) : 3'b000;
      `CHK("gnt", gnt_o, exp_gnt)
      `CHK("rvalid", rvalid_o, exp_rv)
      `CHK("busy", busy_o, (cycle >= busy_from && cycle <= busy_to) || w >= 0)
      `CHK("mem_we", mem_we_o, (w >= 0) && wes[w])
      if (cycle == rv_cycle) `CHK("rdata", rdata_o, rv_data)
      if (w >= 0) begin
        a = addrs[w*AW +: AW];
        `CHK("mem_addr", mem_addr_o, a)
        if (wes[w]) `CHK("mem_din", mem_din_o, wdatas[w*DW +: DW])
        cur_addr  = a;
        busy_from = cycle;
        if (wes[w]) begin
          shadow[ix][a] = wdatas[w*DW +: DW];
          busy_to  = cycle;
          next_gnt = cycle + 2;
        end else begin
          rv_cycle = cycle + 1 + lat;
          rv_port  = w;
          rv_data  = shadow[ix][a];
          busy_to  = cycle + 1 + lat;
          next_gnt = cycle + 3 + lat;
        end
        ptr_m[ix] = (w + 1) % 3;
        pend[w]  = 1'b0;
        req_d[w] = 1'b0;
        // The granted port's operands change; the arbiter must keep its copy.
        addr_d[w*AW +: AW]  = a + 6'd2;
        wdata_d[w*DW +: DW] = ~wdatas[w*DW +: DW];
        we_d[w]             = ~wes[w];
      end else if (cycle > busy_from && cycle <= busy_to) begin
        `CHK("mem_addr_hold", mem_addr_o, cur_addr)
      end
      if (pend == 3'b000 && cycle > busy_to) break;
      if (cycle > 200) begin
        fails++;
        $error("FAIL %s.timeout observed=%0d expected<=200", cur_test, cycle);
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]      ports, wes;
    logic [3*AW-1:0] addrs;
    logic [3*DW-1:0] wdatas;

    rst = 1'b1; mem_load = 1'b1; sel4 = 1'b0;
    req_d = 3'b000; we_d = 3'b000; addr_d = '0; wdata_d = '0;
    for (int i = 0; i < 64; i++) begin
      shadow[0][i] = init_word(i);
      shadow[1][i] = init_word(i);
    end
    ptr_m[0] = 1; ptr_m[1] = 1;
    repeat (2) @(posedge clk);
    #1;
    mem_load = 1'b0;

    cur_test = "reset";
    `CHK("gnt1", bus1.gnt, 3'b000)
    `CHK("rvalid1", bus1.rvalid, 3'b000)
    `CHK("busy1", bus1.busy, 1'b0)
    `CHK("mem_we1", bus1.mem_we, 1'b0)
    `CHK("mem_addr1", bus1.mem_addr, 6'd0)
    `CHK("mem_din1", bus1.mem_din, 32'd0)
    `CHK("rdata1", bus1.rdata, 32'd0)
    `CHK("busy4", bus4.busy, 1'b0)
    `CHK("rdata4", bus4.rdata, 32'd0)
    rst = 1'b0;
    @(posedge clk); #1;

    // Single write then read on port 1
    run_batch("wr_p1", 3'b010, 3'b010, {6'd0, 6'd5, 6'd0}, {32'd0, 32'hDEAD_BEEF, 32'd0});
    run_batch("rd_p1", 3'b010, 3'b000, {6'd0, 6'd5, 6'd0}, '0);

    // Three-way contention, all reads
    run_batch("contend_rd", 3'b111, 3'b000, {6'd12, 6'd11, 6'd10}, '0);

    // Latency sweep at the top address
    sel4 = 1'b0;
    run_batch("lat1_a63", 3'b001, 3'b000, {6'd0, 6'd0, 6'd63}, '0);
    sel4 = 1'b1;
    run_batch("lat4_a63", 3'b001, 3'b000, {6'd0, 6'd0, 6'd63}, '0);
    run_batch("lat4_contend", 3'b111, 3'b010, {6'd40, 6'd41, 6'd42}, {32'h2222_2222, 32'h1111_1111, 32'h0});
    sel4 = 1'b0;

    // Port 2 reads addr 7; its addr moves to 9 after the grant
    run_batch("stable_a7", 3'b100, 3'b000, {6'd7, 6'd0, 6'd0}, '0);

    // Mixed contention and pairs
    run_batch("contend_mix", 3'b111, 3'b101, {6'd20, 6'd21, 6'd22}, {32'hAAAA_0002, 32'h0, 32'hAAAA_0000});
    run_batch("pair_101_a", 3'b101, 3'b000, {6'd20, 6'd0, 6'd22}, '0);
    run_batch("pair_101_b", 3'b101, 3'b000, {6'd22, 6'd0, 6'd20}, '0);
    run_batch("contend_rpt", 3'b111, 3'b000, {6'd1, 6'd2, 6'd3}, '0);
    run_batch("contend_rpt2", 3'b111, 3'b000, {6'd4, 6'd5, 6'd6}, '0);

    // Reset during WAIT of a long read
    cur_test = "rst_wait";
    sel4 = 1'b1;
    we_d = 3'b000; addr_d = {6'd0, 6'd0, 6'd30}; req_d = 3'b001;
    @(posedge clk); #1;
    `CHK("gnt", gnt_o, 3'b001)
    req_d = 3'b000;
    @(posedge clk); #1;
    `CHK("busy_wait", busy_o, 1'b1)
    rst = 1'b1;
    #1;
    `CHK("gnt_rst", gnt_o, 3'b000)
    `CHK("rvalid_rst", rvalid_o, 3'b000)
    `CHK("mem_we_rst", mem_we_o, 1'b0)
    `CHK("busy_rst", busy_o, 1'b0)
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ptr_m[0] = 1; ptr_m[1] = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      `CHK("rvalid_after", rvalid_o, 3'b000)
      `CHK("busy_after", busy_o, 1'b0)
    end

    // Reset while a write is being issued: the write must not land
    cur_test = "rst_issue";
    sel4 = 1'b0;
    we_d = 3'b010; addr_d = {6'd0, 6'd33, 6'd0}; wdata_d = {32'd0, 32'h0BAD_F00D, 32'd0};
    req_d = 3'b010;
    @(posedge clk); #1;
    `CHK("mem_we_issue", mem_we_o, 1'b1)
    req_d = 3'b000;
    rst = 1'b1;
    #1;
    `CHK("mem_we_drop", mem_we_o, 1'b0)
    `CHK("gnt_drop", gnt_o, 3'b000)
    @(posedge clk); #1;
    rst = 1'b0;
    ptr_m[0] = 1; ptr_m[1] = 1;
    @(posedge clk); #1;
    run_batch("rd_after_rst", 3'b010, 3'b000, {6'd0, 6'd33, 6'd0}, '0);

    // Randomized batches on either instance
    for (int i = 0; i < 40; i++) begin
      sel4   = 1'($urandom_range(0, 1));
      ports  = 3'($urandom_range(1, 7));
      wes    = 3'($urandom);
      addrs  = 18'($urandom);
      wdatas = {$urandom, $urandom, $urandom};
      run_batch("random", ports, wes, addrs, wdatas);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
